// File: rtl/cpu_pipeline_fwd.sv
// Five-stage MIPS-subset pipeline (IF/ID/EX/MEM/WB) with EX-stage branch resolution,
// hazard detection and selectable forwarding; both memories sit outside the core.
module cpu_pipeline_fwd #(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 8,
  parameter int RESET_PC   = 0,
  parameter bit FORWARD_EN = 1'b1
) (
  input  logic              clk_CPU,
  input  logic              rst_CPU,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_data,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] resultado,
  output logic              wb_valid,
  output logic [4:0]        wb_reg,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  logic [PC_W-1:0]   pc, pc_plus1;
  logic [31:0]       if_id_instr;
  logic [PC_W-1:0]   if_id_pc1;

  logic              idex_reg_write, idex_mem_read, idex_mem_write, idex_branch, idex_use_imm;
  alu_op_t           idex_alu_op;
  logic [4:0]        idex_dest, idex_rs, idex_rt;
  logic [DATA_W-1:0] idex_rs_val, idex_rt_val, idex_imm;
  logic [PC_W-1:0]   idex_pc1;

  logic              exmem_reg_write, exmem_mem_read, exmem_mem_write;
  logic [4:0]        exmem_dest;
  logic [DATA_W-1:0] exmem_result, exmem_store;

  logic              memwb_reg_write;
  logic [4:0]        memwb_dest;
  logic [DATA_W-1:0] memwb_data;

  logic [DATA_W-1:0] rf [32];

  // ---------------- ID ----------------
  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd;
  logic [DATA_W-1:0] imm_ext, rs_val, rt_val;
  logic              dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_use_imm;
  logic              uses_rs, uses_rt;
  alu_op_t           dec_alu_op;
  logic [4:0]        dec_dest;
  logic              unused_shamt;

  assign op      = if_id_instr[31:26];
  assign rs      = if_id_instr[25:21];
  assign rt      = if_id_instr[20:16];
  assign rd      = if_id_instr[15:11];
  assign funct   = if_id_instr[5:0];
  assign imm_ext = DATA_W'($signed(if_id_instr[15:0]));
  assign unused_shamt = ^if_id_instr[10:6];

  always_comb begin
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    dec_use_imm   = 1'b0;
    dec_alu_op    = ALU_ADD;
    dec_dest      = 5'd0;
    uses_rs       = 1'b0;
    uses_rt       = 1'b0;
    case (op)
      6'h00: begin
        dec_reg_write = 1'b1;
        dec_dest      = rd;
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
        case (funct)
          6'h20: dec_alu_op = ALU_ADD;
          6'h22: dec_alu_op = ALU_SUB;
          6'h24: dec_alu_op = ALU_AND;
          6'h25: dec_alu_op = ALU_OR;
          6'h2A: dec_alu_op = ALU_SLT;
          default: begin
            dec_reg_write = 1'b0;
            dec_dest      = 5'd0;
            uses_rs       = 1'b0;
            uses_rt       = 1'b0;
          end
        endcase
      end
      6'h23: begin
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
        dec_use_imm   = 1'b1;
        dec_dest      = rt;
        uses_rs       = 1'b1;
      end
      6'h2B: begin
        dec_mem_write = 1'b1;
        dec_use_imm   = 1'b1;
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
      end
      6'h04: begin
        dec_branch = 1'b1;
        uses_rs    = 1'b1;
        uses_rt    = 1'b1;
      end
      6'h08: begin
        dec_reg_write = 1'b1;
        dec_use_imm   = 1'b1;
        dec_dest      = rt;
        uses_rs       = 1'b1;
      end
      default: ;
    endcase
    // r0 destinations never write, so they can never be forwarded or stall anything
    if (dec_dest == 5'd0) dec_reg_write = 1'b0;
  end

  always_comb begin
    rs_val = rf[rs];
    rt_val = rf[rt];
    if (memwb_reg_write && memwb_dest == rs) rs_val = memwb_data;
    if (memwb_reg_write && memwb_dest == rt) rt_val = memwb_data;
    if (rs == 5'd0) rs_val = '0;
    if (rt == 5'd0) rt_val = '0;
  end

  // ---------------- hazards ----------------
  logic src_hit_ex, src_hit_mem, stall_req, branch_taken, issue;

  assign src_hit_ex  = idex_reg_write &&
                       ((uses_rs && idex_dest == rs) || (uses_rt && idex_dest == rt));
  assign src_hit_mem = exmem_reg_write &&
                       ((uses_rs && exmem_dest == rs) || (uses_rt && exmem_dest == rt));
  assign stall_req   = FORWARD_EN ? (src_hit_ex && idex_mem_read) : (src_hit_ex || src_hit_mem);
  assign issue       = !branch_taken && !stall_req;

  // ---------------- EX ----------------
  logic [DATA_W-1:0] op_a, op_b_reg, alu_b, alu_res;
  logic [PC_W-1:0]   branch_target;

  always_comb begin
    op_a     = idex_rs_val;
    op_b_reg = idex_rt_val;
    if (FORWARD_EN) begin
      if (exmem_reg_write && !exmem_mem_read && exmem_dest == idex_rs) op_a = exmem_result;
      else if (memwb_reg_write && memwb_dest == idex_rs)               op_a = memwb_data;
      if (exmem_reg_write && !exmem_mem_read && exmem_dest == idex_rt) op_b_reg = exmem_result;
      else if (memwb_reg_write && memwb_dest == idex_rt)               op_b_reg = memwb_data;
    end
  end

  assign alu_b = idex_use_imm ? idex_imm : op_b_reg;

  always_comb begin
    alu_res = '0;
    case (idex_alu_op)
      ALU_ADD: alu_res = op_a + alu_b;
      ALU_SUB: alu_res = op_a - alu_b;
      ALU_AND: alu_res = op_a & alu_b;
      ALU_OR:  alu_res = op_a | alu_b;
      ALU_SLT: alu_res[0] = $signed(op_a) < $signed(alu_b);
      default: alu_res = '0;
    endcase
  end

  assign branch_taken  = idex_branch && (op_a == op_b_reg);
  assign branch_target = idex_pc1 + PC_W'(idex_imm);
  assign pc_plus1      = pc + PC_W'(1);

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk_CPU or posedge rst_CPU) begin
    if (rst_CPU) begin
      pc              <= PC_W'(RESET_PC);
      if_id_instr     <= '0;
      if_id_pc1       <= '0;
      idex_reg_write  <= 1'b0;
      idex_mem_read   <= 1'b0;
      idex_mem_write  <= 1'b0;
      idex_branch     <= 1'b0;
      idex_use_imm    <= 1'b0;
      idex_alu_op     <= ALU_ADD;
      idex_dest       <= '0;
      idex_rs         <= '0;
      idex_rt         <= '0;
      idex_rs_val     <= '0;
      idex_rt_val     <= '0;
      idex_imm        <= '0;
      idex_pc1        <= '0;
      exmem_reg_write <= 1'b0;
      exmem_mem_read  <= 1'b0;
      exmem_mem_write <= 1'b0;
      exmem_dest      <= '0;
      exmem_result    <= '0;
      exmem_store     <= '0;
      memwb_reg_write <= 1'b0;
      memwb_dest      <= '0;
      memwb_data      <= '0;
      stall_cnt       <= '0;
      flush_cnt       <= '0;
    end else begin
      if (branch_taken) begin
        pc          <= branch_target;
        if_id_instr <= '0;
        if (flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
      end else if (stall_req) begin
        if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      end else begin
        pc          <= pc_plus1;
        if_id_instr <= imem_data;
        if_id_pc1   <= pc_plus1;
      end

      // data fields always follow ID; control fields become a bubble on stall or flush
      idex_reg_write  <= issue && dec_reg_write;
      idex_mem_read   <= issue && dec_mem_read;
      idex_mem_write  <= issue && dec_mem_write;
      idex_branch     <= issue && dec_branch;
      idex_use_imm    <= dec_use_imm;
      idex_alu_op     <= dec_alu_op;
      idex_dest       <= issue ? dec_dest : 5'd0;
      idex_rs         <= rs;
      idex_rt         <= rt;
      idex_rs_val     <= rs_val;
      idex_rt_val     <= rt_val;
      idex_imm        <= imm_ext;
      idex_pc1        <= if_id_pc1;

      exmem_reg_write <= idex_reg_write;
      exmem_mem_read  <= idex_mem_read;
      exmem_mem_write <= idex_mem_write;
      exmem_dest      <= idex_dest;
      exmem_result    <= alu_res;
      exmem_store     <= op_b_reg;

      memwb_reg_write <= exmem_reg_write;
      memwb_dest      <= exmem_dest;
      memwb_data      <= exmem_mem_read ? dmem_rdata : exmem_result;
    end
  end

  always_ff @(posedge clk_CPU or posedge rst_CPU) begin
    if (rst_CPU) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (memwb_reg_write) begin
      rf[memwb_dest] <= memwb_data;
    end
  end

  assign imem_addr  = pc;
  assign dmem_addr  = exmem_result;
  assign dmem_wdata = exmem_store;
  assign dmem_we    = exmem_mem_write;
  assign resultado  = memwb_data;
  assign wb_valid   = memwb_reg_write;
  assign wb_reg     = memwb_dest;

endmodule

// File: tb/tb_cpu_pipeline_fwd.sv
// Directed bench: a forwarding core (dut0) and an interlock core (dut1) share one
// instruction memory; each has its own data memory and writeback logger.
module tb_cpu_pipeline_fwd;
  localparam int DW = 32;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_clr = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] imem [256];

  logic [PW-1:0] imem_addr0, imem_addr1;
  logic [31:0]   imem_data0, imem_data1;
  logic [DW-1:0] dmem_addr0, dmem_addr1, dmem_wdata0, dmem_wdata1, dmem_rdata0, dmem_rdata1;
  logic          dmem_we0, dmem_we1, wb_valid0, wb_valid1;
  logic [DW-1:0] resultado0, resultado1;
  logic [4:0]    wb_reg0, wb_reg1;
  logic [15:0]   stall_cnt0, stall_cnt1, flush_cnt0, flush_cnt1;

  cpu_pipeline_fwd #(.DATA_W(DW), .PC_W(PW), .RESET_PC(0), .FORWARD_EN(1'b1)) dut0 (
    .clk_CPU(clk), .rst_CPU(rst), .imem_addr(imem_addr0), .imem_data(imem_data0),
    .dmem_addr(dmem_addr0), .dmem_wdata(dmem_wdata0), .dmem_we(dmem_we0),
    .dmem_rdata(dmem_rdata0), .resultado(resultado0), .wb_valid(wb_valid0),
    .wb_reg(wb_reg0), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0));

  cpu_pipeline_fwd #(.DATA_W(DW), .PC_W(PW), .RESET_PC(0), .FORWARD_EN(1'b0)) dut1 (
    .clk_CPU(clk), .rst_CPU(rst), .imem_addr(imem_addr1), .imem_data(imem_data1),
    .dmem_addr(dmem_addr1), .dmem_wdata(dmem_wdata1), .dmem_we(dmem_we1),
    .dmem_rdata(dmem_rdata1), .resultado(resultado1), .wb_valid(wb_valid1),
    .wb_reg(wb_reg1), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1));

  assign imem_data0 = imem[imem_addr0];
  assign imem_data1 = imem[imem_addr1];

  logic [DW-1:0] dmem0 [256];
  logic [DW-1:0] dmem1 [256];
  assign dmem_rdata0 = dmem0[dmem_addr0[7:0]];
  assign dmem_rdata1 = dmem1[dmem_addr1[7:0]];

  always @(posedge clk or posedge mem_clr) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) begin
        dmem0[i] <= (i == 4) ? 32'h1234 : 32'h0;
        dmem1[i] <= (i == 4) ? 32'h1234 : 32'h0;
      end
    end else begin
      if (dmem_we0) dmem0[dmem_addr0[7:0]] <= dmem_wdata0;
      if (dmem_we1) dmem1[dmem_addr1[7:0]] <= dmem_wdata1;
    end
  end

  // register writes observed at WB, cleared by reset
  logic          seen0 [32];
  logic          seen1 [32];
  logic [DW-1:0] rval0 [32];
  logic [DW-1:0] rval1 [32];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin seen0[i] <= 1'b0; rval0[i] <= '0; end
    end else if (wb_valid0) begin
      seen0[wb_reg0] <= 1'b1;
      rval0[wb_reg0] <= resultado0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin seen1[i] <= 1'b0; rval1[i] <= '0; end
    end else if (wb_valid1) begin
      seen1[wb_reg1] <= 1'b1;
      rval1[wb_reg1] <= resultado1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
  endtask

  // leaves the bench at the falling edge of cycle 0 (PC = RESET_PC, nothing fetched yet)
  task automatic start(input bit clr_mem);
    rst = 1'b1;
    if (clr_mem) begin mem_clr = 1'b1; #1 mem_clr = 1'b0; end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic next_cycle(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_clr = 1'b1; #1 mem_clr = 1'b0;
    clear_imem();
    repeat (2) @(negedge clk);
    n_cmp++; if ({imem_addr0, dmem_we0, wb_valid0, wb_reg0, resultado0, stall_cnt0, flush_cnt0} !== '0) begin
      n_bad++; $display("FAIL reset_dut0 outputs got %h want 0", {imem_addr0, dmem_we0, wb_valid0, wb_reg0, resultado0, stall_cnt0, flush_cnt0}); end
    n_cmp++; if ({imem_addr1, dmem_we1, wb_valid1, wb_reg1, resultado1, stall_cnt1, flush_cnt1} !== '0) begin
      n_bad++; $display("FAIL reset_dut1 outputs got %h want 0", {imem_addr1, dmem_we1, wb_valid1, wb_reg1, resultado1, stall_cnt1, flush_cnt1}); end
  endtask

  task automatic load_chain();
    clear_imem();
    imem[0] = itype(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = itype(6'h08, 5'd1, 5'd2, 16'd3);
    imem[2] = rtype(5'd1, 5'd2, 5'd3, 6'h20);
  endtask

  task automatic test_forward_chain();
    load_chain();
    start(1'b1);
    next_cycle(3);
    n_cmp++; if (wb_valid0 !== 1'b0) begin n_bad++; $display("FAIL chain_c3_idle got %b want 0", wb_valid0); end
    next_cycle(1);
    n_cmp++; if ({wb_valid0, wb_reg0, resultado0} !== {1'b1, 5'd1, 32'd5}) begin
      n_bad++; $display("FAIL chain_c4 got %h want %h", {wb_valid0, wb_reg0, resultado0}, {1'b1, 5'd1, 32'd5}); end
    next_cycle(1);
    n_cmp++; if ({wb_valid0, wb_reg0, resultado0} !== {1'b1, 5'd2, 32'd8}) begin
      n_bad++; $display("FAIL chain_c5 got %h want %h", {wb_valid0, wb_reg0, resultado0}, {1'b1, 5'd2, 32'd8}); end
    next_cycle(1);
    n_cmp++; if ({wb_valid0, wb_reg0, resultado0} !== {1'b1, 5'd3, 32'd13}) begin
      n_bad++; $display("FAIL chain_c6 got %h want %h", {wb_valid0, wb_reg0, resultado0}, {1'b1, 5'd3, 32'd13}); end
    n_cmp++; if (stall_cnt0 !== 16'd0) begin n_bad++; $display("FAIL chain_stalls got %0d want 0", stall_cnt0); end
  endtask

  task automatic test_load_use();
    clear_imem();
    imem[0] = itype(6'h08, 5'd0, 5'd1, 16'd4);
    imem[1] = itype(6'h23, 5'd1, 5'd2, 16'd0);
    imem[2] = rtype(5'd2, 5'd2, 5'd3, 6'h20);
    start(1'b1);
    next_cycle(5);
    n_cmp++; if ({wb_valid0, wb_reg0, resultado0} !== {1'b1, 5'd2, 32'h1234}) begin
      n_bad++; $display("FAIL lw_wb got %h want %h", {wb_valid0, wb_reg0, resultado0}, {1'b1, 5'd2, 32'h1234}); end
    next_cycle(1);
    n_cmp++; if (wb_valid0 !== 1'b0) begin n_bad++; $display("FAIL lu_bubble got %b want 0", wb_valid0); end
    next_cycle(1);
    n_cmp++; if ({wb_valid0, wb_reg0, resultado0} !== {1'b1, 5'd3, 32'h2468}) begin
      n_bad++; $display("FAIL lu_add got %h want %h", {wb_valid0, wb_reg0, resultado0}, {1'b1, 5'd3, 32'h2468}); end
    n_cmp++; if (stall_cnt0 !== 16'd1) begin n_bad++; $display("FAIL lu_stalls got %0d want 1", stall_cnt0); end
  endtask

  task automatic test_branch();
    clear_imem();
    imem[0] = itype(6'h04, 5'd0, 5'd0, 16'd2);
    imem[1] = itype(6'h08, 5'd0, 5'd5, 16'd1);
    imem[2] = itype(6'h08, 5'd0, 5'd6, 16'd1);
    imem[3] = itype(6'h08, 5'd0, 5'd7, 16'd9);
    start(1'b1);
    next_cycle(3);
    n_cmp++; if (imem_addr0 !== 8'd3) begin n_bad++; $display("FAIL br_target got %0d want 3", imem_addr0); end
    next_cycle(4);
    n_cmp++; if ({wb_valid0, wb_reg0, resultado0} !== {1'b1, 5'd7, 32'd9}) begin
      n_bad++; $display("FAIL br_r7 got %h want %h", {wb_valid0, wb_reg0, resultado0}, {1'b1, 5'd7, 32'd9}); end
    next_cycle(2);
    n_cmp++; if ({seen0[5], seen0[6]} !== 2'b00) begin
      n_bad++; $display("FAIL br_shadow_writes got %b want 00", {seen0[5], seen0[6]}); end
    n_cmp++; if ({flush_cnt0, stall_cnt0} !== {16'd1, 16'd0}) begin
      n_bad++; $display("FAIL br_counters got %h want %h", {flush_cnt0, stall_cnt0}, {16'd1, 16'd0}); end
  endtask

  task automatic test_r0_nop();
    clear_imem();
    imem[0] = itype(6'h08, 5'd0, 5'd0, 16'd7);
    imem[1] = rtype(5'd0, 5'd0, 5'd1, 6'h20);
    imem[2] = 32'h0000_0000;
    start(1'b1);
    next_cycle(4);
    n_cmp++; if (wb_valid0 !== 1'b0) begin n_bad++; $display("FAIL r0_write_valid got %b want 0", wb_valid0); end
    next_cycle(1);
    n_cmp++; if ({wb_valid0, wb_reg0, resultado0} !== {1'b1, 5'd1, 32'd0}) begin
      n_bad++; $display("FAIL r0_read got %h want %h", {wb_valid0, wb_reg0, resultado0}, {1'b1, 5'd1, 32'd0}); end
    next_cycle(1);
    n_cmp++; if (wb_valid0 !== 1'b0) begin n_bad++; $display("FAIL nop_valid got %b want 0", wb_valid0); end
  endtask

  task automatic test_alu();
    clear_imem();
    imem[0] = itype(6'h08, 5'd0, 5'd1, 16'hFFFD);
    imem[1] = itype(6'h08, 5'd0, 5'd2, 16'd6);
    imem[2] = rtype(5'd2, 5'd1, 5'd3, 6'h22);
    imem[3] = rtype(5'd1, 5'd2, 5'd4, 6'h2A);
    imem[4] = rtype(5'd1, 5'd2, 5'd5, 6'h24);
    imem[5] = rtype(5'd1, 5'd2, 5'd6, 6'h25);
    imem[6] = rtype(5'd1, 5'd2, 5'd7, 6'h21);
    imem[7] = itype(6'h04, 5'd1, 5'd2, 16'd4);
    imem[8] = rtype(5'd2, 5'd1, 5'd8, 6'h2A);
    start(1'b1);
    next_cycle(14);
    n_cmp++; if (rval0[3] !== 32'd9) begin n_bad++; $display("FAIL alu_sub got %h want 9", rval0[3]); end
    n_cmp++; if (rval0[4] !== 32'd1) begin n_bad++; $display("FAIL alu_slt_true got %h want 1", rval0[4]); end
    n_cmp++; if (rval0[5] !== 32'd4) begin n_bad++; $display("FAIL alu_and got %h want 4", rval0[5]); end
    n_cmp++; if (rval0[6] !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL alu_or got %h want ffffffff", rval0[6]); end
    n_cmp++; if (seen0[7] !== 1'b0) begin n_bad++; $display("FAIL bad_funct_write got %b want 0", seen0[7]); end
    n_cmp++; if ({seen0[8], rval0[8]} !== {1'b1, 32'd0}) begin
      n_bad++; $display("FAIL alu_slt_false got %h want %h", {seen0[8], rval0[8]}, {1'b1, 32'd0}); end
    n_cmp++; if ({flush_cnt0, stall_cnt0} !== 32'd0) begin
      n_bad++; $display("FAIL beq_not_taken counters got %h want 0", {flush_cnt0, stall_cnt0}); end
  endtask

  task automatic test_interlock();
    load_chain();
    start(1'b1);
    next_cycle(4);
    n_cmp++; if ({wb_valid1, wb_reg1, resultado1} !== {1'b1, 5'd1, 32'd5}) begin
      n_bad++; $display("FAIL il_c4 got %h want %h", {wb_valid1, wb_reg1, resultado1}, {1'b1, 5'd1, 32'd5}); end
    next_cycle(3);
    n_cmp++; if ({wb_valid1, wb_reg1, resultado1} !== {1'b1, 5'd2, 32'd8}) begin
      n_bad++; $display("FAIL il_c7 got %h want %h", {wb_valid1, wb_reg1, resultado1}, {1'b1, 5'd2, 32'd8}); end
    next_cycle(3);
    n_cmp++; if ({wb_valid1, wb_reg1, resultado1} !== {1'b1, 5'd3, 32'd13}) begin
      n_bad++; $display("FAIL il_c10 got %h want %h", {wb_valid1, wb_reg1, resultado1}, {1'b1, 5'd3, 32'd13}); end
    n_cmp++; if (stall_cnt1 !== 16'd4) begin n_bad++; $display("FAIL il_stalls got %0d want 4", stall_cnt1); end
  endtask

  task automatic test_reset_midrun();
    clear_imem();
    imem[0] = itype(6'h08, 5'd0, 5'd1, 16'd3);
    imem[1] = itype(6'h2B, 5'd0, 5'd1, 16'd8);
    start(1'b1);
    next_cycle(4);
    n_cmp++; if ({dmem_we0, dmem_addr0, dmem_wdata0} !== {1'b1, 32'd8, 32'd3}) begin
      n_bad++; $display("FAIL sw_in_mem got %h want %h", {dmem_we0, dmem_addr0, dmem_wdata0}, {1'b1, 32'd8, 32'd3}); end
    n_cmp++; if (stall_cnt1 !== 16'd2) begin n_bad++; $display("FAIL il_sw_stalls got %0d want 2", stall_cnt1); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({dmem_we0, wb_valid0, wb_reg0, resultado0, stall_cnt1, flush_cnt0, imem_addr0} !== '0) begin
      n_bad++; $display("FAIL async_reset got %h want 0", {dmem_we0, wb_valid0, wb_reg0, resultado0, stall_cnt1, flush_cnt0, imem_addr0}); end
    clear_imem();
    imem[0] = rtype(5'd1, 5'd1, 5'd2, 6'h20);
    start(1'b0);
    n_cmp++; if (imem_addr0 !== 8'd0) begin n_bad++; $display("FAIL restart_pc got %0d want 0", imem_addr0); end
    next_cycle(4);
    n_cmp++; if ({wb_valid0, wb_reg0, resultado0} !== {1'b1, 5'd2, 32'd0}) begin
      n_bad++; $display("FAIL regs_cleared got %h want %h", {wb_valid0, wb_reg0, resultado0}, {1'b1, 5'd2, 32'd0}); end
    n_cmp++; if (dmem0[8] !== 32'd0) begin n_bad++; $display("FAIL aborted_store got %h want 0", dmem0[8]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forward_chain();
    test_load_use();
    test_branch();
    test_r0_nop();
    test_alu();
    test_interlock();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_pipeline_fwd.md
Name: cpu_pipeline_fwd

Overview:
Parametrised 5-stage MIPS pipeline core (IF/ID/EX/MEM/WB) that succeeds the existing fixed-width R-type pipeline top. It adds asynchronous reset, hazard detection, selectable forwarding or full interlock, and branch resolution in EX with flush. It also adds saturating stall and flush counters. Instruction and data memories sit outside the core on combinational-read ports, so the core is testable standalone.

Parameters:
DATA_W, 32, width of the register file, ALU, data-memory address and data (at least 16)
PC_W, 8, PC width; word-indexed instruction address
RESET_PC, 0, PC value loaded on reset
FORWARD_EN, 1, 1 = EX/MEM and MEM/WB forwarding plus a one-cycle load-use stall; 0 = no forwarding, full interlock

Ports:
clk_CPU  in  1  single clock, rising edge
rst_CPU  in  1  asynchronous, active-high reset
imem_addr  out  PC_W  current PC
imem_data  in  32  instruction at imem_addr, combinational
dmem_addr  out  DATA_W  ALU result of the instruction in MEM
dmem_wdata  out  DATA_W  store data (rt value) of the instruction in MEM
dmem_we  out  1  store in MEM; memory writes on the clk_CPU edge
dmem_rdata  in  DATA_W  load data, combinational from dmem_addr
resultado  out  DATA_W  writeback data of the instruction in WB
wb_valid  out  1  instruction in WB writes a register other than r0
wb_reg  out  5  destination register of the instruction in WB
stall_cnt  out  16  count of stall cycles, saturating at 0xFFFF
flush_cnt  out  16  count of taken-branch flush events, saturating at 0xFFFF

Behaviour:
- Reset (asynchronous, any cycle, including mid-instruction):
  - PC = RESET_PC.
  - All pipeline registers become bubbles (all control bits 0).
  - All 32 registers = 0.
  - Counters = 0.
  - dmem_we = 0, wb_valid = 0, resultado = 0, wb_reg = 0.
- Supported ISA; every other opcode or funct executes as a NOP (no register write, no memory write, no branch):
  - R-type (op 0x00) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - lw 0x23, sw 0x2B, beq 0x04, addi 0x08.
- Arithmetic and width rules:
  - Immediates are sign-extended to DATA_W.
  - add/sub wrap modulo 2^DATA_W; slt is a signed compare that yields 1 or 0.
  - Branch target = PC+1+imm, truncated to PC_W. PC+1 wraps modulo 2^PC_W.
- Latency: an instruction fetched in cycle n is in WB (resultado and wb_* valid) in cycle n+4 when it is not stalled.
- Register file:
  - r0 reads 0; writes to r0 are dropped.
  - A WB write to the register being read in ID in the same cycle bypasses into ID (write-through).
- Forwarding (FORWARD_EN = 1):
  - An EX operand takes EX/MEM.result if EX/MEM writes that register (not r0, not a load).
  - Otherwise it takes the MEM/WB writeback value if MEM/WB writes that register.
  - Otherwise it takes the ID/EX register value. EX/MEM has priority over MEM/WB.
  - sw store data is forwarded the same way.
- Load-use (FORWARD_EN = 1):
  - Condition: ID/EX holds lw with rt != 0, and the instruction in ID sources that rt.
  - Response: PC and IF/ID hold, ID/EX loads a bubble, stall_cnt += 1. Penalty is exactly 1 cycle.
- Interlock (FORWARD_EN = 0):
  - ID stalls while ID/EX or EX/MEM holds a write to a source register of the ID instruction (not r0).
  - Each stall cycle is counted. The MEM/WB case is covered by the write-through bypass.
- beq: resolved in EX on the forwarded operands.
  - Taken: PC = target; IF/ID and ID/EX become bubbles; flush_cnt += 1. Penalty is 2 cycles.
  - Not taken: no penalty.
- Simultaneous events:
  - A taken branch in EX overrides a stall request from ID in the same cycle: PC = target, the stall is not counted, and the flush is counted.
  - Counter saturation holds at 0xFFFF.

Test Plan:
- Forwarding chain: program addi r1,r0,5; addi r2,r1,3; add r3,r1,r2 -> resultado 5, 8, 13 in cycles 4, 5, 6 with wb_reg 1, 2, 3; stall_cnt = 0.
- Load-use: dmem[4] = 0x1234; program addi r1,r0,4; lw r2,0(r1); add r3,r2,r2 -> r3 = 0x2468 written back one cycle late; stall_cnt = 1.
- Taken branch: program beq r0,r0,+2 followed by addi r5,r0,1; addi r6,r0,1; addi r7,r0,9 -> r5 and r6 never written (no wb_valid for them); r7 = 9; flush_cnt = 1.
- r0 and NOPs: program addi r0,r0,7; add r1,r0,r0; instruction 0x00000000 -> r1 = 0; wb_valid = 0 for the r0 write and the NOP; no forwarding of 7.
- Interlock mode (FORWARD_EN = 0), forwarding-chain program -> same final registers (5, 8, 13); stall_cnt = 4 (2 stalls for each dependent instruction).
- Reset mid-run: assert rst_CPU asynchronously between edges while a sw is in MEM -> dmem_we drops immediately; registers and counters read 0; after release the first imem_addr = RESET_PC.
